// File: rtl/xif_cpx_queue.sv
// CUSTOM-0 R-type XIF coprocessor: computes at issue, holds DEPTH speculative results, returns committed ones in order.
// Optional XIF_CPX_STATS_EN adds saturating accepted/killed counters.
module xif_cpx_queue #(
  parameter int         X_ID_WIDTH = 4,
  parameter int         X_NUM_RS   = 2,
  parameter int         XLEN       = 32,
  parameter int         DEPTH      = 4,
  parameter logic [6:0] OPCODE     = 7'b0001011
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [31:0]              issue_req_instr,
  input  logic [X_ID_WIDTH-1:0]    issue_req_id,
  input  logic [X_NUM_RS*XLEN-1:0] issue_req_rs,
  input  logic [X_NUM_RS-1:0]      issue_req_rs_valid,
  output logic                     issue_resp_accept,
  output logic                     issue_resp_writeback,
  input  logic                     commit_valid,
  input  logic [X_ID_WIDTH-1:0]    commit_id,
  input  logic                     commit_kill,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [X_ID_WIDTH-1:0]    result_id,
  output logic [XLEN-1:0]          result_data,
  output logic [4:0]               result_rd,
  output logic                     result_we,
`ifdef XIF_CPX_STATS_EN
  output logic [15:0]              stat_accepted_o,
  output logic [15:0]              stat_killed_o,
`endif
  output logic                     busy_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [AW-1:0]         wr_idx, head_idx, head_d;
  logic [X_ID_WIDTH-1:0] id_mem   [DEPTH];
  logic [4:0]            rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [DEPTH-1:0]      cmt_q, cmt_d, kill_q, kill_d, slot_vld;
  logic                  ours, full, empty, enq, drop, pop, new_head, id_hit;
  logic [XLEN-1:0]       rs1, rs2, alu_res;
  logic                  res_vld_q, res_vld_d, res_we_q, res_we_d;
  logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [XLEN-1:0]       res_data_q, res_data_d;
  logic [4:0]            res_rd_q, res_rd_d;
  logic                  unused_ok;

  function automatic logic [XLEN-1:0] popcnt(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + XLEN'(a[i]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return (sa < sb) ? a : b;
      3'b110:  return (a > b) ? a : b;
      default: return popcnt(a);
    endcase
  endfunction

  assign rs1       = issue_req_rs[XLEN-1:0];
  assign rs2       = issue_req_rs[2*XLEN-1:XLEN];
  assign alu_res   = alu(issue_req_instr[14:12], rs1, rs2);
  assign unused_ok = ^{issue_req_instr[24:15], issue_req_rs, issue_req_rs_valid};

  assign ours                 = (issue_req_instr[6:0] == OPCODE) && (issue_req_instr[31:25] == 7'd0);
  assign full                 = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty                = (wr_ptr_q == rd_ptr_q);
  assign issue_ready          = !ours || ((issue_req_rs_valid[1:0] == 2'b11) && !full);
  assign issue_resp_accept    = ours;
  assign issue_resp_writeback = ours;
  assign enq                  = issue_valid && issue_ready && ours;
  assign count                = wr_ptr_q - rd_ptr_q;
  assign wr_idx               = wr_ptr_q[AW-1:0];
  assign head_idx             = rd_ptr_q[AW-1:0];
  assign drop                 = !empty && kill_q[head_idx];
  assign pop                  = res_vld_q && result_ready;
  assign busy_o               = !empty;
  assign id_hit               = commit_valid && (commit_id == issue_req_id);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_vld[i] = ({1'b0, AW'(i) - head_idx} < count);
  end

  // Next queue state: commits to live entries, enqueue (a same-cycle commit lands on the new entry), head retire
  always_comb begin
    cmt_d    = cmt_q;
    kill_d   = kill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (commit_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_vld[i] && !cmt_q[i] && !kill_q[i] && (id_mem[i] == commit_id)) begin
          if (commit_kill) kill_d[i] = 1'b1;
          else             cmt_d[i]  = 1'b1;
        end
      end
    end
    if (enq) begin
      cmt_d[wr_idx]  = id_hit && !commit_kill;
      kill_d[wr_idx] = id_hit && commit_kill;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end
    if (drop || pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // The next head can be the entry being written this cycle, so bypass the storage for it
  always_comb begin
    head_d     = rd_ptr_d[AW-1:0];
    new_head   = enq && (head_d == wr_idx);
    res_vld_d  = (wr_ptr_d != rd_ptr_d) && cmt_d[head_d] && !kill_d[head_d];
    res_id_d   = '0;
    res_data_d = '0;
    res_rd_d   = '0;
    res_we_d   = 1'b0;
    if (res_vld_d) begin
      res_id_d   = new_head ? issue_req_id : id_mem[head_d];
      res_data_d = new_head ? alu_res : data_mem[head_d];
      res_rd_d   = new_head ? issue_req_instr[11:7] : rd_mem[head_d];
      res_we_d   = (res_rd_d != 5'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmt_q      <= '0;
      kill_q     <= '0;
      res_vld_q  <= 1'b0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmt_q      <= cmt_d;
      kill_q     <= kill_d;
      res_vld_q  <= res_vld_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_we_q   <= res_we_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      id_mem[wr_idx]   <= issue_req_id;
      rd_mem[wr_idx]   <= issue_req_instr[11:7];
      data_mem[wr_idx] <= alu_res;
    end
  end

  assign result_valid = res_vld_q;
  assign result_id    = res_id_q;
  assign result_data  = res_data_q;
  assign result_rd    = res_rd_q;
  assign result_we    = res_we_q;

`ifdef XIF_CPX_STATS_EN
  logic [15:0] stat_acc_q, stat_kill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_acc_q  <= '0;
      stat_kill_q <= '0;
    end else begin
      if (enq && (stat_acc_q != 16'hFFFF))   stat_acc_q  <= stat_acc_q + 16'd1;
      if (drop && (stat_kill_q != 16'hFFFF)) stat_kill_q <= stat_kill_q + 16'd1;
    end
  end

  assign stat_accepted_o = stat_acc_q;
  assign stat_killed_o   = stat_kill_q;
`endif
endmodule

// File: tb/tb_xif_cpx_queue.sv
// Bench for xif_cpx_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_xif_cpx_queue;
  localparam int         DEPTH = 4;
  localparam logic [6:0] OPC   = 7'b0001011;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [31:0] issue_req_instr = '0;
  logic [3:0]  issue_req_id = '0;
  logic [63:0] issue_req_rs = '0;
  logic [1:0]  issue_req_rs_valid = '0;
  logic        issue_resp_accept, issue_resp_writeback;
  logic        commit_valid = 1'b0, commit_kill = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        result_valid, result_ready = 1'b0;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we, busy_o;

  xif_cpx_queue #(.X_ID_WIDTH(4), .X_NUM_RS(2), .XLEN(32), .DEPTH(DEPTH), .OPCODE(OPC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_instr(issue_req_instr),
    .issue_req_id(issue_req_id), .issue_req_rs(issue_req_rs), .issue_req_rs_valid(issue_req_rs_valid),
    .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        cmt;
    logic        kill;
  } ent_t;

  ent_t m_q[$];
  logic exp_vld = 1'b0;
  logic last_rdy, last_acc;
  int   checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] f7, input logic [6:0] op);
    return {f7, 10'd0, f3, rd, op};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? a : b;
      3'd6: return (a > b) ? a : b;
      default: return 32'($countones(a));
    endcase
  endfunction

  task automatic check_outputs();
    check("result_valid", result_valid, exp_vld);
    check("busy", busy_o, m_q.size() > 0);
    if (exp_vld) begin
      check("result_id", result_id, m_q[0].id);
      check("result_data", result_data, m_q[0].data);
      check("result_rd", result_rd, m_q[0].rd);
      check("result_we", result_we, m_q[0].rd != 5'd0);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [3:0] iid,
                      input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv,
                      input logic cv, input logic [3:0] cid, input logic ck, input logic rr);
    logic ours_m, rdy_m;
    ent_t e;
    issue_valid = iv; issue_req_instr = ins; issue_req_id = iid; issue_req_rs = {b, a};
    issue_req_rs_valid = rsv; commit_valid = cv; commit_id = cid; commit_kill = ck; result_ready = rr;
    #1;
    ours_m = (ins[6:0] == OPC) && (ins[31:25] == 7'd0);
    rdy_m  = !ours_m || (rsv == 2'b11 && m_q.size() < DEPTH);
    last_rdy = issue_ready;
    last_acc = issue_resp_accept;
    check("issue_ready", issue_ready, rdy_m);
    if (iv) begin
      check("accept", issue_resp_accept, ours_m);
      check("writeback", issue_resp_writeback, ours_m);
    end
    @(posedge clk_i);
    if (m_q.size() > 0 && m_q[0].kill) void'(m_q.pop_front());
    else if (exp_vld && rr)             void'(m_q.pop_front());
    if (cv) foreach (m_q[i]) if (!m_q[i].cmt && !m_q[i].kill && m_q[i].id == cid) begin
      if (ck) m_q[i].kill = 1'b1; else m_q[i].cmt = 1'b1;
    end
    if (iv && rdy_m && ours_m) begin
      e.id = iid; e.rd = ins[11:7]; e.data = ref_result(ins[14:12], a, b);
      e.cmt = cv && cid == iid && !ck; e.kill = cv && cid == iid && ck;
      m_q.push_back(e);
    end
    exp_vld = m_q.size() > 0 && m_q[0].cmt && !m_q[0].kill;
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 2'b00, 1'b0, 4'd0, 1'b0, rr);
  endtask

  task automatic commit(input logic [3:0] cid, input logic ck, input logic rr);
    step(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 2'b00, 1'b1, cid, ck, rr);
  endtask

  task automatic drain();
    int j;
    for (int k = 0; k < 60 && m_q.size() > 0; k++) begin
      j = -1;
      foreach (m_q[i]) if (j < 0 && !m_q[i].cmt && !m_q[i].kill) j = i;
      if (j >= 0) commit(m_q[j].id, 1'b1, 1'b1);
      else        idle(1'b1);
    end
    check("drain_busy", busy_o, 1'b0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  cid;
    int          n, sel;
    repeat (2) @(negedge clk_i);
    check("rst_ready", issue_ready, 1'b1);
    check("rst_accept", issue_resp_accept, 1'b0);
    check("rst_wb", issue_resp_writeback, 1'b0);
    check("rst_id", result_id, 4'd0);
    check("rst_data", result_data, 32'd0);
    check_outputs();
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: add then commit
    step(1, mk(3'd0, 5'd3, 7'd0, OPC), 4'd2, 32'd5, 32'd7, 2'b11, 0, 4'd0, 0, 0);
    commit(4'd2, 1'b0, 1'b0);
    check("t1_vld", result_valid, 1'b1);
    check("t1_id", result_id, 4'd2);
    check("t1_data", result_data, 32'd12);
    check("t1_rd", result_rd, 5'd3);
    check("t1_we", result_we, 1'b1);
    idle(1'b1);

    // 2: kill older, commit younger
    step(1, mk(3'd2, 5'd4, 7'd0, OPC), 4'd1, 32'hFF, 32'h0F, 2'b11, 0, 4'd0, 0, 0);
    step(1, mk(3'd1, 5'd5, 7'd0, OPC), 4'd2, 32'd0, 32'd1, 2'b11, 0, 4'd0, 0, 0);
    commit(4'd2, 1'b0, 1'b0);
    check("t2_wait", result_valid, 1'b0);
    commit(4'd1, 1'b1, 1'b0);
    n = 0;
    while (!result_valid && n < 5) begin idle(1'b0); n++; end
    check("t2_vld", result_valid, 1'b1);
    check("t2_id", result_id, 4'd2);
    check("t2_data", result_data, 32'hFFFF_FFFF);
    drain();

    // 3: fill, blocked ours, non-custom passes, pop frees
    for (int i = 0; i < 4; i++) step(1, mk(3'd0, 5'd1, 7'd0, OPC), 4'(i), 32'(i), 32'd1, 2'b11, 0, 4'd0, 0, 0);
    step(1, mk(3'd0, 5'd1, 7'd0, OPC), 4'd9, 32'd1, 32'd1, 2'b11, 0, 4'd0, 0, 0);
    check("t3_full_rdy", last_rdy, 1'b0);
    step(1, mk(3'd0, 5'd1, 7'd0, 7'b0110011), 4'd9, 32'd1, 32'd1, 2'b11, 0, 4'd0, 0, 0);
    check("t3_other_rdy", last_rdy, 1'b1);
    check("t3_other_acc", last_acc, 1'b0);
    commit(4'd0, 1'b0, 1'b0);
    idle(1'b1);
    step(1, mk(3'd0, 5'd1, 7'd0, OPC), 4'd4, 32'd1, 32'd1, 2'b11, 0, 4'd0, 0, 0);
    check("t3_freed_rdy", last_rdy, 1'b1);
    drain();

    // 4: backpressure on popcount
    step(1, mk(3'd7, 5'd6, 7'd0, OPC), 4'd5, 32'hF0F0, 32'd0, 2'b11, 0, 4'd0, 0, 0);
    commit(4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_vld", result_valid, 1'b1);
      check("t4_hold_data", result_data, 32'd8);
      idle(1'b0);
    end
    idle(1'b1);
    check("t4_popped", result_valid, 1'b0);

    // 5: same-cycle commit with rd=0; operand not ready
    step(1, mk(3'd0, 5'd0, 7'd0, OPC), 4'd7, 32'd1, 32'd2, 2'b11, 1, 4'd7, 0, 0);
    check("t5_vld", result_valid, 1'b1);
    check("t5_we", result_we, 1'b0);
    step(1, mk(3'd0, 5'd2, 7'd0, OPC), 4'd8, 32'd1, 32'd2, 2'b01, 0, 4'd0, 0, 1);
    check("t5_rsv_rdy", last_rdy, 1'b0);
    step(1, mk(3'd0, 5'd2, 7'd0, OPC), 4'd8, 32'd1, 32'd2, 2'b11, 0, 4'd0, 0, 0);
    check("t5_rsv_ok", last_rdy, 1'b1);
    drain();

    // 6: reset with queued entries
    for (int i = 0; i < 3; i++) step(1, mk(3'd0, 5'd1, 7'd0, OPC), 4'(10 + i), 32'd3, 32'd4, 2'b11, 0, 4'd0, 0, 0);
    commit(4'd10, 1'b0, 1'b0);
    check("t6_pre_vld", result_valid, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_vld", result_valid, 1'b0);
    check("t6_rst_busy", busy_o, 1'b0);
    m_q.delete();
    exp_vld = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    commit(4'd11, 1'b0, 1'b1);
    idle(1'b1);
    check("t6_after_vld", result_valid, 1'b0);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      sel = $urandom_range(0, 9);
      ins = mk(3'($urandom), 5'($urandom), (sel == 8) ? 7'($urandom_range(1, 127)) : 7'd0,
               (sel == 9) ? 7'b0110011 : OPC);
      cid = 4'($urandom);
      n = 0;
      foreach (m_q[i]) if (!m_q[i].cmt && !m_q[i].kill) n++;
      if (n > 0 && $urandom_range(0, 9) < 8) begin
        sel = $urandom_range(0, n - 1);
        foreach (m_q[i]) if (!m_q[i].cmt && !m_q[i].kill) begin
          if (sel == 0) cid = m_q[i].id;
          sel--;
        end
      end
      step($urandom_range(0, 9) < 7, ins, 4'($urandom), $urandom, $urandom,
           ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom),
           $urandom_range(0, 1) == 1, cid, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
